// File: rtl/serial_add64_pkg.sv
// Shared constants, FSM state encoding and the result bundle for the 64-bit slice-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_add64_pkg;

  localparam int SLICE_W = 16;
  localparam int NSLICE  = 4;
  localparam int DATA_W  = SLICE_W * NSLICE;
  localparam int IDX_W   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Registered result presented while out_valid is high.
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } res_t;

endpackage

// File: rtl/serial_add64_if.sv
// Operand/result handshake bundle for serial_add64.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: master drives a, b, cin, in_valid, out_ready; slave drives in_ready, sum, cout, ovf, out_valid.
interface serial_add64_if;
  import serial_add64_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/serial_add64_cla16.sv
// 16-bit carry-lookahead slice: sum plus group propagate/generate for an external carry chain.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a, b operand slices; c carry-in; r slice sum; p group propagate; g group generate.
module serial_add64_cla16
  import serial_add64_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c,
  output logic [SLICE_W-1:0] r,
  output logic               p,
  output logic               g
);

  localparam int GRP = SLICE_W / 4;

  logic [SLICE_W-1:0] bp;
  logic [SLICE_W-1:0] bg;
  logic [SLICE_W-1:0] ci;
  logic [GRP-1:0]     gp;
  logic [GRP-1:0]     gg;
  logic               t_g;
  logic               t_c;
  logic               b_c;
  logic               t_pg;

  // Two-level lookahead: 4-bit groups form their own P/G, group carries
  // come from the group terms, bits inside a group ripple from the group carry.
  // Running scalars keep each stage free of self-referencing vectors.
  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    ci   = '0;
    gp   = '0;
    gg   = '0;
    t_g  = 1'b0;
    t_c  = c;
    b_c  = 1'b0;
    t_pg = 1'b0;

    for (int k = 0; k < GRP; k++) begin
      gp[k] = &bp[4*k +: 4];
      t_g   = 1'b0;
      for (int j = 0; j < 4; j++) begin
        t_g = bg[4*k+j] | (bp[4*k+j] & t_g);
      end
      gg[k] = t_g;
    end

    for (int k = 0; k < GRP; k++) begin
      b_c = t_c;
      for (int j = 0; j < 4; j++) begin
        ci[4*k+j] = b_c;
        b_c       = bg[4*k+j] | (bp[4*k+j] & b_c);
      end
      t_c = gg[k] | (gp[k] & t_c);
    end

    for (int k = 0; k < GRP; k++) begin
      t_pg = gg[k] | (gp[k] & t_pg);
    end
  end

  assign r = bp ^ ci;
  assign p = &gp;
  assign g = t_pg;

endmodule

// File: rtl/serial_add64.sv
// 64-bit adder computed one 16-bit slice per cycle through a single shared CLA slice.
// Latency: result valid 4 cycles after acceptance; one add per 6 cycles at best.
// Backpressure: result held in DONE until out_ready; operands refused (in_ready=0) outside IDLE.
// Ports: clk, rst (sync, active-high); bus = serial_add64_if.slave (operands in, result out).
module serial_add64
  import serial_add64_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  serial_add64_if.slave bus
);

  localparam int BASE_W = $clog2(DATA_W);

  state_t              state_q;
  state_t              state_n;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  res_t                res_q;

  logic                accept;
  logic                step;
  logic                last_slice;
  logic                in_ready;
  logic                out_valid;
  logic [BASE_W-1:0]   base;
  logic [SLICE_W-1:0]  op_a;
  logic [SLICE_W-1:0]  op_b;
  logic [SLICE_W-1:0]  slice_r;
  logic                slice_p;
  logic                slice_g;
  logic                slice_c;

  // Slice select driven straight from the index register.
  assign base       = BASE_W'(idx_q) * BASE_W'(SLICE_W);
  assign op_a       = a_q[base +: SLICE_W];
  assign op_b       = b_q[base +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  serial_add64_cla16 u_cla (
    .a (op_a),
    .b (op_b),
    .c (carry_q),
    .r (slice_r),
    .p (slice_p),
    .g (slice_g)
  );

  assign slice_c = slice_g | (slice_p & carry_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_slice) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        idx_q   <= '0;
      end
      if (step) begin
        res_q.sum[base +: SLICE_W] <= slice_r;
        carry_q                    <= slice_c;
        idx_q                      <= idx_q + 1'b1;
        if (last_slice) begin
          res_q.cout <= slice_c;
          // Carry into bit 63 is recovered from the sum bit: a^b^c = r.
          res_q.ovf  <= op_a[SLICE_W-1] ^ op_b[SLICE_W-1] ^ slice_r[SLICE_W-1] ^ slice_c;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = res_q.sum;
  assign bus.cout      = res_q.cout;
  assign bus.ovf       = res_q.ovf;

endmodule

// File: tb/tb_serial_add64.sv
// Scoreboard bench for serial_add64: directed corner adds, stall, mid-op reset and a random stream.
// Latency: result expected exactly 4 cycles after each acceptance.
// Backpressure: out_ready driven always-high, random, or held low depending on phase.
module tb_serial_add64;
  import serial_add64_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add64_if bus ();

  serial_add64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk      = 0;
  int          n_fail     = 0;
  res_t        exp_q[$];
  res_t        mon_exp;
  res_t        last_obs;
  res_t        stall_exp;
  int unsigned accept_cyc = 0;
  int          rdy_mode   = 0;
  logic        prev_ov    = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic; overflow from operand/result signs.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] t;
    res_t        r;
    t      = {1'b0, a} + {1'b0, b} + {64'd0, c};
    r.sum  = t[63:0];
    r.cout = t[64];
    r.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
    return r;
  endfunction

  // out_ready driver: 0 = always ready, 1 = random stalls, 2 = held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: results transfer at the posedge following a negedge with valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov)
          check("latency", 64'(cyc - accept_cyc), 64'd4);
        if (bus.out_valid && bus.out_ready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_out: result with no pending op, sum=%h expected none", bus.sum);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sum", bus.sum, mon_exp.sum);
            check("cout", 64'(bus.cout), 64'(mon_exp.cout));
            check("ovf", 64'(bus.ovf), 64'(mon_exp.ovf));
          end
          last_obs.sum  = bus.sum;
          last_obs.cout = bus.cout;
          last_obs.ovf  = bus.ovf;
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  // Enter/leave at posedge+1; returns once the operands are taken.
  task automatic do_add(input logic [63:0] a, input logic [63:0] b, input logic c);
    int n   = 0;
    bit acc = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.cin      = 1'($urandom_range(0, 1));
    n_chk++;
    if (acc) begin
      exp_q.push_back(model(a, b, c));
      accept_cyc = cyc;
    end else begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1 within 300 cycles", bus.in_ready);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    #1 rdy_mode = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw_ov;
    int n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    last_obs      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner cases, compared against literal answers too.
    do_add(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0);
    wait_drain();
    check("small_sum", last_obs.sum, 64'h3);
    check("small_cout", 64'(last_obs.cout), 64'd0);
    check("small_ovf", 64'(last_obs.ovf), 64'd0);

    do_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_drain();
    check("wrap_sum", last_obs.sum, 64'h0);
    check("wrap_cout", 64'(last_obs.cout), 64'd1);
    check("wrap_ovf", 64'(last_obs.ovf), 64'd0);

    do_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_drain();
    check("ovf_sum", last_obs.sum, 64'h8000_0000_0000_0000);
    check("ovf_cout", 64'(last_obs.cout), 64'd0);
    check("ovf_ovf", 64'(last_obs.ovf), 64'd1);

    // Hold the result for 10 cycles while offering a new operand pair.
    set_mode(2);
    do_add(64'h8000_0000_0000_0000, 64'h8000_0000_0000_1234, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    stall_exp = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_sum", bus.sum, stall_exp.sum);
      check("stall_cout", 64'(bus.cout), 64'(stall_exp.cout));
      check("stall_ovf", 64'(bus.ovf), 64'(stall_exp.ovf));
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    set_mode(0);
    wait_drain();

    // Reset sampled at acceptance edge + 2 aborts the operation.
    do_add(64'h0000_1234_5678_9ABC, 64'h0000_0000_0000_9ABC, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    saw_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) saw_ov = 1'b1;
    end
    check("abort_never_valid", 64'(saw_ov), 64'd0);
    @(posedge clk);
    #1;
    do_add(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0);
    wait_drain();
    check("post_rst_sum", last_obs.sum, 64'h1FFFF);

    // Random back-to-back stream with random consumer stalls.
    set_mode(1);
    for (int i = 0; i < 100; i++) begin
      do_add({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    set_mode(0);
    wait_drain();

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1);
  end

endmodule
